// File: rtl/dmem_port_responder_pkg.sv
// Shared types and lane helpers for the data-memory port responder.
// Request queue entries carry order, direction, address and store data.
package dmem_port_responder_pkg;

  localparam logic [1:0] OrdByte = 2'd0;
  localparam logic [1:0] OrdHalf = 2'd1;
  localparam logic [1:0] OrdWord = 2'd2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0]  order;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  // Byte lanes touched by an access; order 3 behaves as a word.
  function automatic logic [3:0] lane_en(input logic [1:0] order, input logic [1:0] a);
    logic [3:0] en;
    case (order)
      OrdByte: en = 4'b0001 << a;
      OrdHalf: en = a[1] ? 4'b1100 : 4'b0011;
      default: en = 4'b1111;
    endcase
    return en;
  endfunction

  // Replicate right-justified store data so every selected lane sees its bytes.
  function automatic logic [31:0] store_lanes(input logic [1:0] order, input logic [31:0] data);
    logic [31:0] w;
    case (order)
      OrdByte: w = {4{data[7:0]}};
      OrdHalf: w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] order, input logic [1:0] a,
                                               input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {a, 3'b000};
    case (order)
      OrdByte: r = {24'b0, sh[7:0]};
      OrdHalf: r = a[1] ? {16'b0, word[31:16]} : {16'b0, word[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_req_fifo.sv
// Synchronous request FIFO with per-entry valid bits; a flush invalidates
// queued loads in place while stores keep their slots and are still performed.
module dmem_req_fifo
  import dmem_port_responder_pkg::*;
#(
  parameter int unsigned P_DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  req_t                     i_req,
  input  logic                     i_pop,
  input  logic                     i_flush_loads,
  output req_t                     o_head,
  output logic                     o_head_valid,
  output logic [$clog2(P_DEPTH):0] o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PW = $clog2(P_DEPTH);

  req_t               r_mem [P_DEPTH];
  logic [P_DEPTH-1:0] r_vld;
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [PW:0]        r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == P_DEPTH[PW:0]);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_req;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_flush_loads) begin
        for (int i = 0; i < int'(P_DEPTH); i++) begin
          if (!r_mem[i].rw) r_vld[i] <= 1'b0;
        end
      end
      // A request pushed during a flush is new and survives it.
      if (w_push) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign o_head       = r_mem[r_rptr];
  assign o_head_valid = r_vld[r_rptr];
  assign o_count      = r_count;

endmodule

// File: rtl/dmem_port_responder.sv
// Data-memory responder: queues core REQ/LOCK requests and performs them on a
// byte-lane word RAM after a fixed latency, returning one VALID per load.
module dmem_port_responder
  import dmem_port_responder_pkg::*;
#(
  parameter int unsigned P_WORDS   = 1024,
  parameter int unsigned P_LATENCY = 2,
  parameter int unsigned P_QDEPTH  = 4
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iDATA_REQ,
  output logic        oDATA_LOCK,
  input  logic [1:0]  iDATA_ORDER,
  input  logic        iDATA_RW,
  input  logic [13:0] iDATA_TID,
  input  logic [1:0]  iDATA_MMUMOD,
  input  logic [31:0] iDATA_PDT,
  input  logic [31:0] iDATA_ADDR,
  input  logic [31:0] iDATA_DATA,
  input  logic        iFLASH,
  output logic        oDATA_VALID,
  output logic [63:0] oDATA_DATA
);

  localparam int unsigned AW = $clog2(P_WORDS);
  localparam int unsigned QW = $clog2(P_QDEPTH);

  state_e      r_state;
  state_e      w_state_d;
  logic [3:0]  r_cnt;
  req_t        r_work;
  logic [31:0] r_rdata;
  logic        r_valid;
  logic [31:0] r_odata;

  req_t        w_req;
  req_t        w_head;
  logic        w_head_valid;
  logic [QW:0] w_count;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_start;
  logic        w_commit;
  logic        w_resp;
  logic [AW-1:0] w_idx;
  logic [3:0]  w_we;
  logic [31:0] w_wdata;
  logic [31:0] w_rword;
  logic        w_unused_ok;

  assign w_req = '{order: iDATA_ORDER, rw: iDATA_RW, addr: iDATA_ADDR, data: iDATA_DATA};
  assign oDATA_LOCK = iRESET || w_full;

  dmem_req_fifo #(
    .P_DEPTH (P_QDEPTH)
  ) u_fifo (
    .i_clk         (iCLOCK),
    .i_rst         (iRESET),
    .i_push        (iDATA_REQ && !oDATA_LOCK),
    .i_req         (w_req),
    .i_pop         (w_pop),
    .i_flush_loads (iFLASH),
    .o_head        (w_head),
    .o_head_valid  (w_head_valid),
    .o_count       (w_count),
    .o_full        (w_full),
    .o_empty       (w_empty)
  );

  always_comb begin
    w_state_d = r_state;
    w_pop     = 1'b0;
    w_start   = 1'b0;
    w_commit  = 1'b0;
    w_resp    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          // Invalidated loads, and loads popped during a flush, are discarded here.
          if (w_head_valid && (w_head.rw || !iFLASH)) begin
            w_start   = 1'b1;
            w_state_d = StWait;
          end
        end
      end
      StWait: begin
        if (iFLASH && !r_work.rw) begin
          w_state_d = StIdle;
        end else if (r_cnt == 4'd1) begin
          w_commit  = 1'b1;
          w_state_d = r_work.rw ? StIdle : StResp;
        end
      end
      StResp: begin
        w_resp    = !iFLASH;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_work  <= '0;
      r_rdata <= '0;
      r_valid <= 1'b0;
      r_odata <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_start) begin
        r_work <= w_head;
        r_cnt  <= 4'(P_LATENCY);
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit && !r_work.rw) r_rdata <= load_extract(r_work.order, r_work.addr[1:0], w_rword);
      r_valid <= w_resp;
      if (w_resp) r_odata <= r_rdata;
    end
  end

  // Address bits above the RAM depth are ignored, so accesses wrap.
  assign w_idx   = r_work.addr[AW+1:2];
  assign w_wdata = store_lanes(r_work.order, r_work.data);
  assign w_we    = (w_commit && r_work.rw && !iRESET) ?
                   lane_en(r_work.order, r_work.addr[1:0]) : 4'b0000;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [7:0] r_mem [P_WORDS];
    always_ff @(posedge iCLOCK) begin
      if (w_we[k]) r_mem[w_idx] <= w_wdata[8*k +: 8];
    end
    assign w_rword[8*k +: 8] = r_mem[w_idx];
  end

  assign oDATA_VALID = r_valid;
  assign oDATA_DATA  = {32'b0, r_odata};

  assign w_unused_ok = ^{iDATA_TID, iDATA_MMUMOD, iDATA_PDT, r_work.addr[31:AW+2], w_count};

endmodule

// File: tb/tb_dmem_port_responder.sv
// Directed bench for dmem_port_responder: a serial vector table plus hand-written
// sequences for queue-full, flush, reset-mid-operation and reset behaviour.
module tb_dmem_port_responder;

  localparam int unsigned P_WORDS   = 1024;
  localparam int unsigned P_LATENCY = 2;
  localparam int unsigned P_QDEPTH  = 4;
  localparam int          TMO       = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        lock;
  logic [1:0]  ord;
  logic        rw;
  logic [13:0] tid;
  logic [1:0]  mmumod;
  logic [31:0] pdt;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flash;
  logic        valid;
  logic [63:0] rdata;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit          rw;
    logic [1:0]  ord;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  dmem_port_responder #(
    .P_WORDS   (P_WORDS),
    .P_LATENCY (P_LATENCY),
    .P_QDEPTH  (P_QDEPTH)
  ) dut (
    .iCLOCK       (clk),
    .iRESET       (rst),
    .iDATA_REQ    (req),
    .oDATA_LOCK   (lock),
    .iDATA_ORDER  (ord),
    .iDATA_RW     (rw),
    .iDATA_TID    (tid),
    .iDATA_MMUMOD (mmumod),
    .iDATA_PDT    (pdt),
    .iDATA_ADDR   (addr),
    .iDATA_DATA   (wdata),
    .iFLASH       (flash),
    .oDATA_VALID  (valid),
    .oDATA_DATA   (rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out after %0d cycles, expected a response", name, TMO);
  endtask

  task automatic add(input bit r, input logic [1:0] o, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] e);
    vec_t v;
    v.rw = r; v.ord = o; v.addr = a; v.data = d; v.exp = e;
    vecs.push_back(v);
  endtask

  // Present one request and return just after its accept edge.
  task automatic issue(input bit r, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] d);
    int guard = 0;
    req = 1'b1; rw = r; ord = o; addr = a; wdata = d;
    while (lock && guard < TMO) begin
      step();
      guard++;
    end
    if (guard >= TMO) timeout("issue_lock");
    step();
    req = 1'b0;
  endtask

  task automatic wait_valid(output int n, output logic [63:0] d);
    n = 0;
    d = '0;
    while (n < TMO) begin
      step();
      n++;
      if (valid) begin
        d = rdata;
        break;
      end
    end
  endtask

  task automatic load_chk(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] exp);
    int          n;
    logic [63:0] d;
    issue(1'b0, o, a, 32'h0);
    wait_valid(n, d);
    if (n >= TMO && !valid) begin
      timeout(name);
    end else begin
      check(name, d, {32'h0, exp});
      check({name, "_lat"}, 64'(n), 64'(P_LATENCY + 2));
      step();
      check({name, "_pulse"}, 64'(valid), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] sa [5];
    logic [31:0] sd [5];
    int          acc;
    int          held;
    int          guard;
    int          pulses;
    logic        l;

    rst = 1'b1; req = 1'b0; ord = 2'd0; rw = 1'b0; tid = 14'h1abc; mmumod = 2'd1;
    pdt = 32'hcafe_0000; addr = '0; wdata = '0; flash = 1'b0;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_lock%0d", i), 64'(lock), 64'd1);
      check($sformatf("rst_valid%0d", i), 64'(valid), 64'd0);
      check($sformatf("rst_data%0d", i), rdata, 64'd0);
    end
    rst = 1'b0;
    step();
    check("rst_release_lock", 64'(lock), 64'd0);

    // Serial vector table: stores drain, loads are checked for data and latency.
    add(1, 2'd2, 32'h10,       32'hDEADBEEF, 32'h0);
    add(0, 2'd2, 32'h10,       32'h0,        32'hDEADBEEF);
    add(1, 2'd2, 32'h20,       32'h11223344, 32'h0);
    add(1, 2'd0, 32'h23,       32'h000000AA, 32'h0);
    add(0, 2'd2, 32'h20,       32'h0,        32'hAA223344);
    add(0, 2'd1, 32'h22,       32'h0,        32'h0000AA22);
    add(0, 2'd0, 32'h21,       32'h0,        32'h00000033);
    add(0, 2'd1, 32'h20,       32'h0,        32'h00003344);
    add(1, 2'd2, 32'h24,       32'h0,        32'h0);
    add(1, 2'd1, 32'h27,       32'h1234CAFE, 32'h0);
    add(0, 2'd2, 32'h24,       32'h0,        32'hCAFE0000);
    add(0, 2'd0, 32'h26,       32'h0,        32'h000000FE);
    add(0, 2'd0, 32'h27,       32'h0,        32'h000000CA);
    add(1, 2'd3, 32'h31,       32'h55667788, 32'h0);
    add(0, 2'd2, 32'h32,       32'h0,        32'h55667788);
    add(1, 2'd0, 32'h11,       32'hFFFFFF5A, 32'h0);
    add(0, 2'd2, 32'h10,       32'h0,        32'hDEAD5AEF);
    add(1, 2'd2, 32'h0,        32'hA5A50001, 32'h0);
    add(0, 2'd2, 32'h1000,     32'h0,        32'hA5A50001);
    add(0, 2'd3, 32'h80001003, 32'h0,        32'hA5A50001);
    add(0, 2'd1, 32'h1003,     32'h0,        32'h0000A5A5);

    foreach (vecs[i]) begin
      if (vecs[i].rw) begin
        issue(1'b1, vecs[i].ord, vecs[i].addr, vecs[i].data);
        repeat (6) step();
      end else begin
        load_chk($sformatf("vec%0d", i), vecs[i].ord, vecs[i].addr, vecs[i].exp);
      end
    end

    // Queue full: a load keeps the FSM busy while five stores stream in.
    sa[0] = 32'h40; sa[1] = 32'h44; sa[2] = 32'h48; sa[3] = 32'h4C; sa[4] = 32'h4C;
    sd[0] = 32'h1;  sd[1] = 32'h2;  sd[2] = 32'h3;  sd[3] = 32'h44; sd[4] = 32'h55;
    req = 1'b1; rw = 1'b0; ord = 2'd2; addr = 32'h10;
    step();
    acc = 0; held = 0; guard = 0;
    while (acc < 5 && guard < TMO) begin
      rw = 1'b1; ord = 2'd2; addr = sa[acc]; wdata = sd[acc];
      l = lock;
      step();
      guard++;
      if (!l) begin
        acc++;
        if (acc == 4) check("q_lock_after4", 64'(lock), 64'd1);
      end else begin
        held++;
      end
    end
    req = 1'b0;
    if (guard >= TMO) timeout("q_fill");
    check("q_fifth_held", 64'(held > 0), 64'd1);
    repeat (30) step();
    load_chk("q_rd40", 2'd2, 32'h40, 32'h1);
    load_chk("q_rd44", 2'd2, 32'h44, 32'h2);
    load_chk("q_rd48", 2'd2, 32'h48, 32'h3);
    load_chk("q_rd4c", 2'd2, 32'h4C, 32'h55);

    // Flush: [load A, store B=5, load C], flush while A is waiting.
    req = 1'b1; rw = 1'b0; ord = 2'd2; addr = 32'h60;
    step();
    rw = 1'b1; wdata = 32'h5;
    step();
    rw = 1'b0;
    step();
    req = 1'b0; flash = 1'b1;
    step();
    flash = 1'b0;
    pulses = 0;
    repeat (20) begin
      if (valid) pulses++;
      step();
    end
    check("flush_no_valid", 64'(pulses), 64'd0);
    load_chk("flush_store_kept", 2'd2, 32'h60, 32'h5);

    // Reset while a store waits: it must not be committed.
    issue(1'b1, 2'd2, 32'h70, 32'h11);
    repeat (6) step();
    issue(1'b1, 2'd2, 32'h70, 32'h77);
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check("midrst_lock", 64'(lock), 64'd0);
    check("midrst_valid", 64'(valid), 64'd0);
    load_chk("midrst_not_committed", 2'd2, 32'h70, 32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
